// File: rtl/param_counter_pkg.sv
// param_counter_pkg
// Shared definitions for the parameterised up/down counter family.
//   MODE_UP / MODE_DOWN : encodings of the direction input.
//   clamp_load()        : restricts a parallel-load value to the counter's
//                         legal range 0..max_val.
package param_counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // Loads above the modulus are clamped to the modulus, so a load can never
    // place the counter in an unreachable state. Operates on 32 bits so one
    // function serves every WIDTH (1..32); callers cast the result back.
    function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                               input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/up_down_next.sv
// up_down_next
// Combinational next-state logic for the up/down counter: given the current
// count and direction it returns the count after one enabled step and whether
// that step crosses a boundary with wrap-around.
// Parameters:
//   WIDTH    : counter width in bits
//   MAX      : top count value
//   SATURATE : 0 = wrap at the boundaries, 1 = hold at the boundaries
// Ports:
//   count      in   WIDTH  current count (always within 0..MAX)
//   mode       in   1      1 = up, 0 = down
//   next_count out  WIDTH  count after one enabled step
//   wrap_next  out  1      step wraps MAX->0 (up) or 0->MAX (down)
module up_down_next
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 9,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_W = '0;
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    always_comb begin
        next_count = count;
        wrap_next  = 1'b0;
        if (mode == MODE_UP) begin
            if (count == MAX_W) begin
                // Saturating mode simply keeps the default (hold at MAX).
                if (!SATURATE) begin
                    next_count = ZERO_W;
                    wrap_next  = 1'b1;
                end
            end else begin
                next_count = count + ONE_W;
            end
        end else begin
            if (count == ZERO_W) begin
                if (!SATURATE) begin
                    next_count = MAX_W;
                    wrap_next  = 1'b1;
                end
            end else begin
                next_count = count - ONE_W;
            end
        end
    end

endmodule

// File: rtl/param_up_down_counter.sv
// param_up_down_counter
// Synchronous up/down counter over the range 0..MAX with parallel load,
// wrap-or-saturate boundary policy and cascade flags.
// Parameters:
//   WIDTH    : counter width in bits, 1..32
//   MAX      : top count value, 1..2**WIDTH-1
//   SATURATE : 0 = wrap at the boundaries, 1 = hold at the boundaries
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous active-low reset
//   en       in   1      count enable (0 holds)
//   mode     in   1      1 = up, 0 = down
//   load     in   1      parallel load strobe (beats en)
//   load_val in   WIDTH  value to load, clamped to MAX
//   count    out  WIDTH  registered count
//   tc       out  1      terminal count for the current direction (combinational)
//   wrap     out  1      registered one-cycle pulse when count shows a wrapped value
module param_up_down_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 9,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // 64-bit arithmetic so the upper-bound test is valid for WIDTH = 32.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("param_up_down_counter: WIDTH must be in 1..32");
        end
        if (MAX < 1) begin : g_bad_max_low
            $error("param_up_down_counter: MAX must be >= 1");
        end
        if (64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max_high
            $error("param_up_down_counter: MAX must fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_W = '0;

    logic [WIDTH-1:0] next_count;
    logic             wrap_next;
    logic [WIDTH-1:0] load_clamped;

    up_down_next #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .mode       (mode),
        .next_count (next_count),
        .wrap_next  (wrap_next)
    );

    assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= ZERO_W;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= next_count;
            wrap  <= wrap_next;
        end else begin
            wrap  <= 1'b0;
        end
    end

    // Independent of en so a cascaded stage can use it directly as its enable.
    assign tc = ((mode == MODE_UP)   && (count == MAX_W)) ||
                ((mode == MODE_DOWN) && (count == ZERO_W));

endmodule

// File: tb/tb_param_up_down_counter.sv
module tb_param_up_down_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main instance: WIDTH=4, MAX=9, wrapping
    logic       reset_a = 1'b0, en_a = 1'b1, mode_a = 1'b1, load_a = 1'b0;
    logic [3:0] lv_a = '0;
    logic [3:0] count_a;
    logic       tc_a, wrap_a;

    param_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_dut (
        .clk(clk), .reset(reset_a), .en(en_a), .mode(mode_a), .load(load_a),
        .load_val(lv_a), .count(count_a), .tc(tc_a), .wrap(wrap_a));

    // Saturating instance
    logic       reset_s = 1'b0, en_s = 1'b0, mode_s = 1'b1, load_s = 1'b0;
    logic [3:0] lv_s = '0;
    logic [3:0] count_s;
    logic       tc_s, wrap_s;

    param_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset_s), .en(en_s), .mode(mode_s), .load(load_s),
        .load_val(lv_s), .count(count_s), .tc(tc_s), .wrap(wrap_s));

    // Minimal instance: WIDTH=1, MAX=1, back-to-back wraps
    logic reset_m = 1'b0, en_m = 1'b0, mode_m = 1'b1, load_m = 1'b0;
    logic lv_m = 1'b0;
    logic count_m, tc_m, wrap_m;

    param_up_down_counter #(.WIDTH(1), .MAX(1), .SATURATE(1'b0)) u_min (
        .clk(clk), .reset(reset_m), .en(en_m), .mode(mode_m), .load(load_m),
        .load_val(lv_m), .count(count_m), .tc(tc_m), .wrap(wrap_m));

    // Two-digit decimal cascade
    logic       reset_c = 1'b0, en_c = 1'b0;
    logic       mode_c = 1'b1;
    logic [3:0] count_lo, count_hi;
    logic       tc_lo, tc_hi, wrap_lo, wrap_hi;
    logic       en_hi;
    assign en_hi = en_c && tc_lo;

    param_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_lo (
        .clk(clk), .reset(reset_c), .en(en_c), .mode(mode_c), .load(1'b0),
        .load_val(4'd0), .count(count_lo), .tc(tc_lo), .wrap(wrap_lo));

    param_up_down_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_hi (
        .clk(clk), .reset(reset_c), .en(en_hi), .mode(mode_c), .load(1'b0),
        .load_val(4'd0), .count(count_hi), .tc(tc_hi), .wrap(wrap_hi));

    initial begin
        int exp;
        int expd [5];

        // Reset held with en=1, mode=up
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_count", 32'(count_a), 0);
            check("reset_wrap", 32'(wrap_a), 0);
        end
        reset_a = 1'b1;
        step();
        check("post_reset_1", 32'(count_a), 1);
        step();
        check("post_reset_2", 32'(count_a), 2);

        // Up wrap from 0
        reset_a = 1'b0;
        step();
        check("upwrap_start", 32'(count_a), 0);
        check("upwrap_start_tc", 32'(tc_a), 0);
        reset_a = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp = k % 10;
            check($sformatf("upwrap_count_%0d", k), 32'(count_a), 32'(exp));
            check($sformatf("upwrap_wrap_%0d", k), 32'(wrap_a), (k == 10) ? 1 : 0);
            check($sformatf("upwrap_tc_%0d", k), 32'(tc_a), (exp == 9) ? 1 : 0);
        end

        // At 1; count up to 3, then down through the lower boundary
        step();
        step();
        check("up_to_3", 32'(count_a), 3);
        mode_a = 1'b0;
        expd = '{2, 1, 0, 9, 8};
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("down_count_%0d", k), 32'(count_a), 32'(expd[k]));
            check($sformatf("down_wrap_%0d", k), 32'(wrap_a), (expd[k] == 9) ? 1 : 0);
            check($sformatf("down_tc_%0d", k), 32'(tc_a), (expd[k] == 0) ? 1 : 0);
        end

        // Load beats en, no step applied on top
        mode_a = 1'b1;
        load_a = 1'b1;
        lv_a   = 4'd5;
        step();
        check("load_5", 32'(count_a), 5);
        check("load_5_wrap", 32'(wrap_a), 0);
        lv_a = 4'd14;
        step();
        check("load_clamp_14", 32'(count_a), 9);
        reset_a = 1'b0;
        lv_a    = 4'd3;
        step();
        check("reset_beats_load", 32'(count_a), 0);
        reset_a = 1'b1;

        // Hold at 7
        lv_a = 4'd7;
        step();
        load_a = 1'b0;
        en_a   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("hold_count_%0d", k), 32'(count_a), 7);
            check($sformatf("hold_wrap_%0d", k), 32'(wrap_a), 0);
        end

        // tc follows mode combinationally without an edge
        load_a = 1'b1;
        lv_a   = 4'd9;
        step();
        load_a = 1'b0;
        check("tc_up_at_max", 32'(tc_a), 1);
        mode_a = 1'b0;
        #1;
        check("tc_down_at_max", 32'(tc_a), 0);
        step();
        check("hold_at_max", 32'(count_a), 9);

        // Saturating instance
        step();
        reset_s = 1'b1;
        load_s  = 1'b1;
        en_s    = 1'b1;
        lv_s    = 4'd8;
        step();
        check("sat_load_8", 32'(count_s), 8);
        load_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("sat_up_%0d", k), 32'(count_s), 9);
            check($sformatf("sat_up_wrap_%0d", k), 32'(wrap_s), 0);
        end
        check("sat_up_tc", 32'(tc_s), 1);
        load_s = 1'b1;
        lv_s   = 4'd0;
        step();
        load_s = 1'b0;
        mode_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("sat_down_%0d", k), 32'(count_s), 0);
            check($sformatf("sat_down_wrap_%0d", k), 32'(wrap_s), 0);
        end
        check("sat_down_tc", 32'(tc_s), 1);

        // MAX=1: wrap on every other edge in both directions
        step();
        reset_m = 1'b1;
        en_m    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("min_up_%0d", k), 32'(count_m), 32'(k % 2));
            check($sformatf("min_up_wrap_%0d", k), 32'(wrap_m), (k % 2 == 0) ? 1 : 0);
        end
        mode_m = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("min_down_%0d", k), 32'(count_m), 32'(k % 2));
            check($sformatf("min_down_wrap_%0d", k), 32'(wrap_m), (k % 2 == 1) ? 1 : 0);
        end

        // Two-digit cascade counting 0..24
        step();
        check("casc_reset_lo", 32'(count_lo), 0);
        check("casc_reset_hi", 32'(count_hi), 0);
        reset_c = 1'b1;
        en_c    = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("casc_lo_%0d", k), 32'(count_lo), 32'(k % 10));
            check($sformatf("casc_hi_%0d", k), 32'(count_hi), 32'((k / 10) % 10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_up_down_counter.md
# param_up_down_counter

Parametrised successor to the team's synchronous 4-bit up/down counter. Counts up or down by one per enabled clock over a programmable modulus 0..MAX, with a parallel load, a wrap-or-saturate policy and terminal-count/wrap flags for cascading. Intended as the common counter primitive for timers, address generators and cascaded multi-digit counters elsewhere in the design.

## Interface
- WIDTH, 4: counter width in bits, 1..32.
- MAX, 9: top count value; legal range 1..2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (acts on rising clk while 0).
- en  in  1  count enable; 0 holds the count.
- mode  in  1  direction: 1 = up, 0 = down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  registered count value.
- tc  out  1  terminal count, combinational from count and mode.
- wrap  out  1  registered one-cycle pulse marking a boundary wrap.

## Operation
- Priority at each rising edge: reset=0 > load=1 > en=1 > hold.
- Reset: count = 0, wrap = 0.
- Load: count = load_val if load_val <= MAX, else MAX (clamped). wrap = 0. en is ignored that cycle.
- Up (mode=1, en=1): count < MAX gives count+1. At count == MAX: SATURATE=0 gives 0 with wrap=1; SATURATE=1 holds MAX with wrap=0.
- Down (mode=0, en=1): count > 0 gives count-1. At count == 0: SATURATE=0 gives MAX with wrap=1; SATURATE=1 holds 0 with wrap=0.
- Hold (en=0, no load): count unchanged, wrap = 0.
- tc = (mode && count == MAX) || (!mode && count == 0). tc is independent of en, so it can gate the en of the next cascaded stage.
- All arithmetic is done in WIDTH bits. count never leaves 0..MAX, including after a load. No out-of-range state is reachable.
- mode may change on any cycle. The new direction applies at the next enabled edge.
- No state machine beyond the count register and the wrap flag.

## Timing
- Latency: one clock from en/load/mode sampled to the updated count.
- wrap is high for exactly the one cycle in which count shows the wrapped value (0 after an up-wrap, MAX after a down-wrap).
- Back-to-back wraps are possible (MAX=1 with en held high) and give a wrap pulse on each wrapping edge.
- tc follows count and mode combinationally within the same cycle. It has no register delay.
- Reset asserted mid-count: the next edge forces count=0 and wrap=0, regardless of load or en.
- load and en both high: the load wins, and no count step is applied on top of the loaded value.
- After reset deasserts, counting resumes on the first edge where en=1.

## Structure
- Shared package param_counter_pkg:
  - MODE_UP = 1'b1 and MODE_DOWN = 1'b0.
  - A function returning the clamped load value.
- Single module with no sub-module required.
- The next-value logic may optionally be split out as up_down_next, a combinational function of count, mode, MAX and SATURATE. It returns both the next count and the wrap flag.
- Elaboration-time checks:
  - MAX >= 1.
  - MAX <= 2**WIDTH-1.
  - WIDTH <= 32.

## Test plan
- Reset: WIDTH=4, MAX=9, en=1, mode=1, reset=0 for 3 edges, then release. Required: count=0 throughout reset, then 1, 2, ... on later edges.
- Up wrap: MAX=9, SATURATE=0, mode=1, en=1 from 0 for 12 edges. Required: 0..9, 0, 1, with wrap=1 only in the cycle count=0 after 9, and tc=1 while count=9.
- Down wrap plus direction switch: count up to 3, set mode=0 for 5 edges. Required: 2, 1, 0, 9, 8, with wrap pulsing when 9 appears and tc=1 at count=0.
- Saturate: SATURATE=1, MAX=9, load 8, mode=1, en=1 for 4 edges. Required: 9, 9, 9, 9 with wrap never 1. Then mode=0 from 0: holds 0.
- Load priority and clamp:
  - load=1, en=1, load_val=5: count=5 on the next edge, with no increment.
  - load_val=14 with MAX=9: count=9.
  - reset=0 together with load=1: count=0.
- Hold and cascade: en=0 for 4 edges at count=7 keeps count 7 and wrap 0. Two instances are chained with en_hi = en && tc_lo. Required: the high digit increments exactly when the low digit wraps 9 to 0.
